// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_e   frame FSM states (IDLE/START/DATA/PARITY/STOP)
//   PARITY_*       parity mode selector values
//   ERR_*          error-code bits reported alongside rx_err
//   parity_bad()   parity check of a received frame
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [1:0] ERR_FRAME  = 2'b01;
  localparam logic [1:0] ERR_PARITY = 2'b10;

  // data_xor is the XOR of all data bits, par_bit the received parity bit.
  // Odd parity expects the total count of ones to be odd, even expects it even.
  function automatic logic parity_bad(input logic data_xor, input logic par_bit,
                                      input int mode);
    case (mode)
      PARITY_ODD:  return ~(data_xor ^ par_bit);
      PARITY_EVEN: return data_xor ^ par_bit;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   d_i    in  asynchronous input
//   q_o    out synchronised output (RST_VAL while in reset)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/rx_uart.sv
// rx_uart: serial UART receiver (start bit, BIT_MAX data bits LSB-first,
// optional parity bit, one stop bit).
//   clk          in  system clock
//   rst          in  asynchronous active-low reset
//   rx           in  serial line, asynchronous, idles high
//   rx_data      out last good byte, held until the next good frame
//   rx_valid     out 1-cycle pulse: rx_data updated
//   rx_err       out 1-cycle pulse: frame rejected
//   rx_err_code  out {parity error, framing error}, meaningful while rx_err=1
//   rx_busy      out high from start-edge detection until return to idle
module rx_uart
  import uart_pkg::*;
#(
  parameter int BPS_MAX = 5208,
  parameter int BIT_MAX = 8,
  parameter int PARITY  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [BIT_MAX-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_err,
  output logic [1:0]         rx_err_code,
  output logic               rx_busy
);

  localparam int CW = $clog2(BPS_MAX);
  localparam logic [CW-1:0] BPS_LAST = CW'(BPS_MAX - 1);
  localparam logic [CW-1:0] BPS_HALF = CW'(BPS_MAX / 2 - 1);
  localparam logic [3:0]    BIT_LAST = 4'(BIT_MAX - 1);

  logic               rx_s;
  logic               rx_prev_q;
  logic               fall;
  uart_state_e        state_q, state_d;
  logic [CW-1:0]      bps_q, bps_d;
  logic [3:0]         bit_q, bit_d;
  logic [BIT_MAX-1:0] shift_q, shift_d;
  logic               par_err_q, par_err_d;
  logic [BIT_MAX-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic               busy_q, busy_d;
  logic               bps_tick;
  logic               half_tick;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign fall      = !rx_s && rx_prev_q;
  assign bps_tick  = (bps_q == BPS_LAST);
  assign half_tick = (bps_q == BPS_HALF);

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    code_d    = 2'b00;
    busy_d    = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d   = ST_START;
          busy_d    = 1'b1;
          bit_d     = 4'd0;
          par_err_d = 1'b0;
        end
      end
      ST_START: begin
        // Mid start bit: a line already back high was only a glitch.
        if (half_tick) begin
          if (!rx_s) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        // Shifting in from the top leaves the first (LSB) bit at bit 0.
        if (bps_tick) begin
          shift_d = {rx_s, shift_q[BIT_MAX-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bps_tick) begin
          par_err_d = parity_bad(^shift_q, rx_s, PARITY);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (bps_tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (rx_s && !par_err_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = (par_err_q ? ERR_PARITY : 2'b00) | (!rx_s ? ERR_FRAME : 2'b00);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Bit timer restarts on every state entry and sits at zero while idle.
    if (state_q == ST_IDLE || state_d != state_q || bps_tick) begin
      bps_d = '0;
    end else begin
      bps_d = bps_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rx_prev_q <= 1'b1;
      bps_q     <= '0;
      bit_q     <= 4'd0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_prev_q <= rx_s;
      bps_q     <= bps_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_err      = err_q;
  assign rx_err_code = code_q;
  assign rx_busy     = busy_q;

endmodule

// File: tb/tb_rx_uart.sv
// tb_rx_uart: randomized frames on two receivers (8N1 and 8E1, 16 clk/bit)
// compared against a frame-level reference model of outcome, data and timing.
module tb_rx_uart;

  localparam int BPS = 16;

  typedef struct packed {
    logic        p;
    logic        is_err;
    logic [7:0]  data;
    logic [1:0]  code;
    logic [31:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, rx_valid_p, rx_err, rx_err_p, rx_busy, rx_busy_p;
  logic [1:0] rx_err_code, rx_err_code_p;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  ev_t  exp_q[$];
  ev_t  act_q[$];
  logic [7:0] last_good [2];

  rx_uart #(.BPS_MAX(BPS), .BIT_MAX(8), .PARITY(0)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .rx_err_code(rx_err_code), .rx_busy(rx_busy));

  rx_uart #(.BPS_MAX(BPS), .BIT_MAX(8), .PARITY(2)) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_err(rx_err_p), .rx_err_code(rx_err_code_p), .rx_busy(rx_busy_p));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Record every output pulse with the cycle it appeared in.
  always @(negedge clk) begin
    if (rx_valid && rx_err)     check("excl_valid_err", 1, 0);
    if (rx_valid_p && rx_err_p) check("excl_valid_err_p", 1, 0);
    if (rx_valid)   act_q.push_back('{1'b0, 1'b0, rx_data, 2'b00, cyc});
    if (rx_err)     act_q.push_back('{1'b0, 1'b1, 8'h00, rx_err_code, cyc});
    if (rx_valid_p) act_q.push_back('{1'b1, 1'b0, rx_data_p, 2'b00, cyc});
    if (rx_err_p)   act_q.push_back('{1'b1, 1'b1, 8'h00, rx_err_code_p, cyc});
  end

  task automatic drive_bit(input bit p, input logic v, input int n);
    if (p) rx_p = v; else rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: outcome from the frame contents, pulse at a fixed offset
  // (2 sync + half bit + all remaining bits + 1) from the start edge.
  task automatic send_frame(input bit p, input logic [7:0] d, input logic stopb,
                            input logic parb);
    ev_t  e;
    logic par_bad;
    int   lat;
    lat = 2 + BPS / 2 + (8 + (p ? 1 : 0) + 1) * BPS + 1;
    par_bad = p ? ((($countones(d) + int'(parb)) % 2) != 0) : 1'b0;
    e.p      = p;
    e.is_err = !stopb || par_bad;
    e.data   = d;
    e.code   = {par_bad, !stopb};
    e.cyc    = 32'(cyc + lat);
    if (!e.is_err) last_good[p] = d;
    exp_q.push_back(e);
    drive_bit(p, 1'b0, BPS);
    for (int i = 0; i < 8; i++) drive_bit(p, d[i], BPS);
    if (p) drive_bit(p, parb, BPS);
    drive_bit(p, stopb, BPS);
  endtask

  task automatic drain();
    ev_t e, a;
    repeat (4) @(posedge clk);
    #1;
    check("evt_count", act_q.size(), exp_q.size());
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      check("evt_inst", a.p, e.p);
      check("evt_kind", a.is_err, e.is_err);
      if (e.is_err) check("err_code", a.code, e.code);
      else          check("valid_data", a.data, e.data);
      check("pulse_cycle", a.cyc, e.cyc);
    end
    exp_q.delete();
    act_q.delete();
    check("rx_data_hold", rx_data, last_good[0]);
    check("rx_data_hold_p", rx_data_p, last_good[1]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, rx_data, 0);
    check({tag, "_valid"}, rx_valid, 0);
    check({tag, "_err"}, rx_err, 0);
    check({tag, "_code"}, rx_err_code, 0);
    check({tag, "_busy"}, rx_busy, 0);
    check({tag, "_data_p"}, rx_data_p, 0);
    check({tag, "_busy_p"}, rx_busy_p, 0);
  endtask

  initial begin
    int hi_seen, lo_at, c0;
    logic [7:0] d;
    logic sb, pb;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Good 8N1 frame, then a frame with a low stop bit.
    send_frame(0, 8'hA5, 1'b1, 1'b0);
    drive_bit(0, 1'b1, BPS);
    drain();
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    drive_bit(0, 1'b1, BPS);
    drain();

    // Start glitch: busy rises, then drops by mid start bit, no pulse.
    hi_seen = 0;
    lo_at = -1;
    c0 = cyc;
    fork
      begin
        drive_bit(0, 1'b0, 5);
        drive_bit(0, 1'b1, 25);
      end
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        if (rx_busy) hi_seen = 1;
        else if (hi_seen != 0 && lo_at < 0) lo_at = cyc - c0;
      end
    join
    check("glitch_busy_rose", hi_seen, 1);
    check("glitch_busy_drop_in_time", (lo_at > 0 && lo_at <= 11) ? 1 : 0, 1);
    drain();

    // Back-to-back frames with no idle gap.
    send_frame(0, 8'h00, 1'b1, 1'b0);
    send_frame(0, 8'hFF, 1'b1, 1'b0);
    drive_bit(0, 1'b1, BPS);
    drain();

    // Break: one framing error, a constant low never retriggers.
    send_frame(0, 8'h00, 1'b0, 1'b0);
    drive_bit(0, 1'b0, 20 * BPS);
    drive_bit(0, 1'b1, BPS);
    drain();

    // Even parity: wrong then right parity bit for 0x01.
    send_frame(1, 8'h01, 1'b1, 1'b0);
    drive_bit(1, 1'b1, BPS);
    send_frame(1, 8'h01, 1'b1, 1'b1);
    drive_bit(1, 1'b1, BPS);
    drain();

    // Randomized frames on both receivers.
    for (int k = 0; k < 40; k++) begin
      bit p;
      p  = (k % 4 == 3);
      d  = 8'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      pb = 1'($urandom);
      send_frame(p, d, sb, pb);
      drive_bit(p, 1'b1, sb ? $urandom_range(0, 20) : $urandom_range(4, 20));
      drain();
    end

    // Reset in the middle of data bit 3, then a clean frame.
    drive_bit(0, 1'b0, BPS);
    drive_bit(0, 1'b0, BPS);
    drive_bit(0, 1'b1, BPS);
    drive_bit(0, 1'b0, BPS);
    drive_bit(0, 1'b1, BPS / 2);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    exp_q.delete();
    act_q.delete();
    @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_no_pulse", act_q.size(), 0);
    send_frame(0, 8'h5A, 1'b1, 1'b0);
    drive_bit(0, 1'b1, BPS);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
